// File: rtl/fir_tap_streamer.sv
// Delay-line feeder for a single-MAC FIR filter. It stores one sample per frame in a
// circular buffer, then streams the newest TAPS samples newest-first with their tap index.
module fir_tap_streamer #(
  parameter int WIDTH = 8,
  parameter int TAPS  = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [WIDTH-1:0]        sample_in,
  input  logic                    sample_valid_in,
  output logic                    sample_ready_out,
  output logic [WIDTH-1:0]        tap_out,
  output logic [$clog2(TAPS)-1:0] tap_index_out,
  output logic                    tap_valid_out,
  output logic                    frame_start_out,
  output logic                    frame_last_out
);
  localparam int IW = $clog2(TAPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] buf_r [TAPS];
  logic [IW-1:0]    wr_ptr_r, wr_ptr_s;
  logic [IW-1:0]    newest_r, newest_s;
  logic [IW-1:0]    idx_r, idx_s;
  logic [IW-1:0]    nxt_idx_s, rd_ptr_s;
  logic [WIDTH-1:0] tap_r, tap_s;
  logic             valid_r, valid_s;
  logic             start_r, start_s;
  logic             last_r, last_s;
  logic             ready_r, ready_s;
  logic             accept_s;

  assign accept_s  = sample_valid_in && ready_r;
  assign nxt_idx_s = idx_r + IW'(1);
  assign rd_ptr_s  = newest_r - nxt_idx_s;

  // Next-state and next-output logic; tap 0 bypasses the buffer with the incoming sample.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    tap_s    = tap_r;
    valid_s  = valid_r;
    start_s  = 1'b0;
    last_s   = 1'b0;
    ready_s  = ready_r;
    newest_s = newest_r;
    wr_ptr_s = wr_ptr_r;
    if (accept_s) begin
      state_s  = STREAM;
      idx_s    = '0;
      tap_s    = sample_in;
      valid_s  = 1'b1;
      start_s  = 1'b1;
      ready_s  = 1'b0;
      newest_s = wr_ptr_r;
      wr_ptr_s = wr_ptr_r + IW'(1);
    end else begin
      case (state_r)
        IDLE: begin
          idx_s   = '0;
          tap_s   = '0;
          valid_s = 1'b0;
          ready_s = 1'b1;
        end
        STREAM: begin
          if (idx_r == LAST_IDX) begin
            state_s = IDLE;
            idx_s   = '0;
            tap_s   = '0;
            valid_s = 1'b0;
            ready_s = 1'b1;
          end else begin
            idx_s   = nxt_idx_s;
            tap_s   = buf_r[rd_ptr_s];
            valid_s = 1'b1;
            last_s  = (nxt_idx_s == LAST_IDX);
            ready_s = (nxt_idx_s == LAST_IDX);
          end
        end
        default: begin
          state_s = IDLE;
          idx_s   = '0;
          tap_s   = '0;
          valid_s = 1'b0;
          ready_s = 1'b0;
        end
      endcase
    end
  end

  // Control state and registered tap outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r  <= IDLE;
      idx_r    <= '0;
      tap_r    <= '0;
      valid_r  <= 1'b0;
      start_r  <= 1'b0;
      last_r   <= 1'b0;
      ready_r  <= 1'b0;
      newest_r <= '0;
      wr_ptr_r <= '0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      tap_r    <= tap_s;
      valid_r  <= valid_s;
      start_r  <= start_s;
      last_r   <= last_s;
      ready_r  <= ready_s;
      newest_r <= newest_s;
      wr_ptr_r <= wr_ptr_s;
    end
  end

  // Delay-line storage, zeroed by reset so unwritten taps read as 0.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < TAPS; i++) begin
        buf_r[i] <= '0;
      end
    end else if (accept_s) begin
      buf_r[wr_ptr_r] <= sample_in;
    end
  end

  assign sample_ready_out = ready_r;
  assign tap_out          = tap_r;
  assign tap_index_out    = idx_r;
  assign tap_valid_out    = valid_r;
  assign frame_start_out  = start_r;
  assign frame_last_out   = last_r;

endmodule

// File: tb/tb_fir_tap_streamer.sv
// Randomised self-checking bench for fir_tap_streamer: a sample-history model predicts
// every tap frame, and a per-cycle compare process checks the DUT against it.
module tb_fir_tap_streamer;
  localparam int WIDTH = 8;
  localparam int TAPS  = 32;
  localparam int IW    = $clog2(TAPS);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [IW-1:0]    idx;
    logic             start;
    logic             last;
  } tap_t;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic [WIDTH-1:0] sample_in = '0;
  logic             sample_valid_in = 1'b0;
  logic             sample_ready_out;
  logic [WIDTH-1:0] tap_out;
  logic [IW-1:0]    tap_index_out;
  logic             tap_valid_out;
  logic             frame_start_out;
  logic             frame_last_out;

  int checks = 0;
  int failures = 0;
  int acc_count = 0;

  logic [WIDTH-1:0] hist[$];
  tap_t             expq[$];
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] obs [TAPS];

  fir_tap_streamer #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .sample_ready_out(sample_ready_out),
    .tap_out         (tap_out),
    .tap_index_out   (tap_index_out),
    .tap_valid_out   (tap_valid_out),
    .frame_start_out (frame_start_out),
    .frame_last_out  (frame_last_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each acceptance appends to the sample history and queues a frame of
  // TAPS records, tap k being the sample accepted k acceptances earlier (0 if none).
  always @(posedge clk_in) begin
    if (rst_in) begin
      tap_t cur;
      bit   has;
      int   n;
      if (sample_valid_in && m_ready) begin
        hist.push_back(sample_in);
        acc_count++;
        n = hist.size() - 1;
        for (int k = 0; k < TAPS; k++) begin
          tap_t rec;
          rec.idx   = IW'(k);
          rec.data  = (n - k >= 0) ? hist[n - k] : '0;
          rec.start = (k == 0);
          rec.last  = (k == TAPS - 1);
          expq.push_back(rec);
        end
      end
      has = (expq.size() > 0);
      cur = '0;
      if (has) cur = expq.pop_front();
      m_ready = (expq.size() == 0);
      #1;
      if (rst_in) begin
        chk("tap_valid", 32'(tap_valid_out), 32'(has));
        chk("ready", 32'(sample_ready_out), 32'(m_ready));
        if (has) begin
          chk("tap_data", 32'(tap_out), 32'(cur.data));
          chk("tap_index", 32'(tap_index_out), 32'(cur.idx));
          chk("frame_start", 32'(frame_start_out), 32'(cur.start));
          chk("frame_last", 32'(frame_last_out), 32'(cur.last));
          obs[cur.idx] = tap_out;
        end else begin
          chk("idle_start", 32'(frame_start_out), 32'(0));
          chk("idle_last", 32'(frame_last_out), 32'(0));
        end
      end
    end
  end

  task automatic pulse_reset();
    rst_in = 1'b0;
    sample_valid_in = 1'b0;
    hist.delete();
    expq.delete();
    m_ready = 1'b0;
    for (int i = 0; i < TAPS; i++) obs[i] = 'x;
    #1;
    chk("rst_tap", 32'(tap_out), 32'(0));
    chk("rst_index", 32'(tap_index_out), 32'(0));
    chk("rst_valid", 32'(tap_valid_out), 32'(0));
    chk("rst_start", 32'(frame_start_out), 32'(0));
    chk("rst_last", 32'(frame_last_out), 32'(0));
    chk("rst_ready", 32'(sample_ready_out), 32'(0));
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic send(input logic [WIDTH-1:0] v);
    int start_cnt;
    bit got;
    start_cnt = acc_count;
    got = 1'b0;
    @(negedge clk_in);
    sample_in = v;
    sample_valid_in = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clk_in);
      #2;
      if (acc_count != start_cnt) got = 1'b1;
    end
    chk("send_accepted", 32'(got), 32'(1));
    @(negedge clk_in);
    sample_valid_in = 1'b0;
  endtask

  task automatic wait_frame();
    repeat (TAPS + 2) @(posedge clk_in);
    #2;
  endtask

  initial begin
    int last_acc;
    int acc0;
    pulse_reset();
    chk("ready_before_edge", 32'(sample_ready_out), 32'(0));
    repeat (50) @(posedge clk_in);
    #2;

    pulse_reset();
    send(8'h05);
    wait_frame();
    chk("single_t0", 32'(obs[0]), 32'h05);
    chk("single_t1", 32'(obs[1]), 32'h00);
    chk("single_t31", 32'(obs[31]), 32'h00);

    pulse_reset();
    send(8'h01);
    send(8'h02);
    send(8'h03);
    wait_frame();
    chk("seq_t0", 32'(obs[0]), 32'h03);
    chk("seq_t1", 32'(obs[1]), 32'h02);
    chk("seq_t2", 32'(obs[2]), 32'h01);
    chk("seq_t3", 32'(obs[3]), 32'h00);

    pulse_reset();
    for (int i = 0; i < 40; i++) send(WIDTH'(i));
    wait_frame();
    chk("wrap_t0", 32'(obs[0]), 32'd39);
    chk("wrap_t1", 32'(obs[1]), 32'd38);
    chk("wrap_t31", 32'(obs[31]), 32'd8);

    // Backpressure: valid held high, value bumps after every acceptance.
    pulse_reset();
    @(negedge clk_in);
    sample_in = 8'hA0;
    sample_valid_in = 1'b1;
    acc0 = acc_count;
    last_acc = acc_count;
    repeat (160) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (acc_count != last_acc) begin
        sample_in = sample_in + 8'h01;
        last_acc = acc_count;
      end
    end
    sample_valid_in = 1'b0;
    chk("bp_accepts", 32'(acc_count - acc0), 32'd5);
    wait_frame();
    chk("bp_t0", 32'(obs[0]), 32'hA4);
    chk("bp_t1", 32'(obs[1]), 32'hA3);
    chk("bp_t4", 32'(obs[4]), 32'hA0);
    chk("bp_t5", 32'(obs[5]), 32'h00);

    // Random traffic with idle gaps between frames.
    pulse_reset();
    for (int i = 0; i < 12; i++) begin
      send(WIDTH'($urandom_range(255, 0)));
      repeat ($urandom_range(3, 0)) @(posedge clk_in);
    end
    wait_frame();

    // Reset pulsed during tap 10 of a frame.
    pulse_reset();
    send(8'h33);
    repeat (10) @(posedge clk_in);
    #3;
    chk("mid_index", 32'(tap_index_out), 32'd10);
    pulse_reset();
    repeat (40) @(posedge clk_in);
    #2;
    send(8'h7F);
    wait_frame();
    chk("post_rst_t0", 32'(obs[0]), 32'h7F);
    chk("post_rst_t1", 32'(obs[1]), 32'h00);
    chk("post_rst_t31", 32'(obs[31]), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_tap_streamer.md
# fir_tap_streamer

Delay-line feeder that produces the serial tap stream for a single-MAC FIR filter. It accepts one audio sample per frame over a valid/ready handshake and stores it in a TAPS-deep circular buffer. It then emits the newest TAPS samples one per clock, newest first, each tagged with its tap index, so that a downstream MAC can compute y[n] = Σ c[k]·x[n−k]. It sits between the audio sample source and the filter datapath.

## Interface
- WIDTH, default 8: sample width in bits.
- TAPS, default 32: delay-line depth and taps per frame; a power of two ≥ 4.

- clk_in  input  1  system clock; all logic on its rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- sample_in  input  WIDTH  new audio sample.
- sample_valid_in  input  1  sample_in is valid.
- sample_ready_out  output  1  block can accept a sample this cycle.
- tap_out  output  WIDTH  delayed sample x[n−k].
- tap_index_out  output  $clog2(TAPS)  k, the coefficient index for tap_out.
- tap_valid_out  output  1  tap_out and tap_index_out are valid.
- frame_start_out  output  1  high with k = 0.
- frame_last_out  output  1  high with k = TAPS−1.

## Operation
- Storage:
  - TAPS×WIDTH circular buffer and write pointer wr_ptr.
  - Reset clears all entries to 0 and sets wr_ptr to 0.
- Acceptance: a sample is accepted on a rising edge where sample_valid_in && sample_ready_out.
  - The sample is written at wr_ptr.
  - wr_ptr advances modulo TAPS, wrapping TAPS−1 → 0.
- States:
  - IDLE: sample_ready_out = 1. Acceptance → STREAM with k = 0.
  - STREAM: emit tap k = buf[(newest_ptr − k) mod TAPS] and increment k.
    - At k = TAPS−1 with no acceptance → IDLE.
    - At k = TAPS−1 with acceptance → STREAM with k = 0 for the new frame.
- Tap 0 equals the sample just accepted. The write and the k = 0 read must not see a stale entry; use a bypass or equivalent.
- Entries never written since reset read as 0.
- sample_valid_in while sample_ready_out = 0:
  - The sample is not accepted, and the buffer and pointer are unchanged.
  - Upstream holds the sample until it is accepted.
- Values are raw passthrough: no arithmetic and no sign change on samples.

## Timing
- Reset values while rst_in = 0:
  - tap_out = 0, tap_index_out = 0.
  - tap_valid_out = 0, frame_start_out = 0, frame_last_out = 0.
  - sample_ready_out = 0.
- After reset release: sample_ready_out = 1 from the cycle after the first rising edge.
- All tap outputs are registered.
  - Acceptance at edge E0 → tap k is presented after edge E0+k, for k = 0..TAPS−1.
  - Latency from acceptance to tap 0 is 1 cycle.
  - tap_valid_out stays high for exactly TAPS consecutive cycles per frame.
- sample_ready_out during a frame:
  - Low from the cycle after E0 through the cycle showing tap TAPS−2.
  - High in the cycle showing tap TAPS−1.
- Back-to-back frames: acceptance at edge E0+TAPS−1 makes tap 0 of the next frame follow tap TAPS−1 with no bubble. Maximum rate is 1 sample per TAPS cycles.
- Reset asserted mid-frame:
  - Outputs go to their reset values immediately (asynchronously).
  - The frame is abandoned and the buffer is zeroed.
  - Nothing resumes after release.

## Test plan
- Reset release → sample_ready_out rises after 1 edge. tap_valid_out stays 0 for 50 idle cycles.
- Single sample 8'h05 after reset → 32 taps: index 0 = 5, indices 1..31 = 0. frame_start_out only at index 0, frame_last_out only at index 31.
- Samples 1, 2, 3, each accepted when ready → third frame taps = 3, 2, 1, then 29 zeros.
- Wrap-around: samples i = 0..39 → frame for sample 39 gives taps 39, 38, …, 8, in index order 0..31.
- Backpressure: sample_valid_in held high throughout with an incrementing value on each acceptance.
  - Acceptances occur only in the tap-31 cycle.
  - Frames are contiguous, with tap_valid_out continuously 1.
  - Samples presented during STREAM are not lost.
- rst_in pulsed low during tap 10 → outputs 0 immediately. After release, sample 8'h7F yields 7F followed by 31 zeros.
